// File: rtl/stage_f_pkg.sv
// stage_f_pkg: shared widths, defaults and PC helper for the fetch stage
package stage_f_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC00000;
  localparam int MAX_OUTSTANDING_LIMIT = 8;
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/stage_f_fifo.sv
// fetch_pc_fifo: circular buffer of live request addresses, clear beats push/pop
module fetch_pc_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  // next pointers, storage and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d = clear ? '0 : push ? nxt(wr_q) : wr_q;
    rd_d = clear ? '0 : pop ? nxt(rd_q) : rd_q;
    cnt_d = clear ? '0 : cnt_q + CW'(push) - CW'(pop);
    if (push && !clear) mem_d[wr_q] = din;
    dout = mem_q[rd_q];
    count = cnt_q;
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
  end
  // pointer and count state
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: count gates every read
  always_ff @(posedge clock) mem_q <= mem_d;
endmodule

// File: rtl/stage_f.sv
// stage_f: instruction fetch stage with in-order memory port and redirect handling
module stage_f
  import stage_f_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            restart,
  input  logic [XLEN-1:0] restart_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            i_valid,
  output logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] i_npc
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT) begin : g_bad_depth
    $error("MAX_OUTSTANDING out of range 1..8");
  end
  logic [CW-1:0] live, discard_q, discard_d;
  logic [CW:0] outstanding;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, head_pc;
  logic [XLEN-1:0] i_instr_q, i_instr_d, i_pc_q, i_pc_d, i_npc_q, i_npc_d;
  logic i_valid_q, i_valid_d, rsp, accept, deliver, fifo_full, fifo_empty, unused_bits;
  fetch_pc_fifo #(.DEPTH(MAX_OUTSTANDING), .W(XLEN)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (restart),
    .push  (accept),
    .pop   (deliver),
    .din   (fetch_pc_q),
    .dout  (head_pc),
    .count (live),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  // issue, response routing and redirect bookkeeping
  always_comb begin
    unused_bits = ^restart_pc[1:0];
    outstanding = {1'b0, live} + {1'b0, discard_q};
    imem_req = ~reset & ~restart & ~fifo_full & (outstanding < (CW+1)'(MAX_OUTSTANDING));
    imem_addr = fetch_pc_q;
    accept = imem_req & imem_ready;
    rsp = imem_rvalid & (outstanding != '0);
    deliver = ~restart & rsp & (discard_q == '0) & ~fifo_empty;
    discard_d = restart ? discard_q + live - CW'(rsp) :
                (rsp && discard_q != '0) ? discard_q - CW'(1) : discard_q;
    fetch_pc_d = restart ? {restart_pc[XLEN-1:2], 2'b00} : accept ? pc_next(fetch_pc_q) : fetch_pc_q;
    i_valid_d = deliver;
    i_instr_d = deliver ? imem_rdata : i_instr_q;
    i_pc_d = deliver ? head_pc : i_pc_q;
    i_npc_d = deliver ? pc_next(head_pc) : i_npc_q;
    i_valid = i_valid_q;
    i_instr = i_instr_q;
    i_pc = i_pc_q;
    i_npc = i_npc_q;
  end
  // fetch PC, stale-response counter and decode-facing registers
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      discard_q <= '0;
      i_valid_q <= 1'b0;
      i_instr_q <= '0;
      i_pc_q <= '0;
      i_npc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q <= discard_d;
      i_valid_q <= i_valid_d;
      i_instr_q <= i_instr_d;
      i_pc_q <= i_pc_d;
      i_npc_q <= i_npc_d;
    end
  end
endmodule
